// File: rtl/fsm_c_ters_pkg.sv
// Shared definitions for the sum/difference operand decoder.
//   W_DEF   : default operand width
//   state_t : controller state encoding (3 bits)
package fsm_c_ters_pkg;

  localparam int W_DEF = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD  = 3'd1,
    ADDR = 3'd2,
    SUB  = 3'd3,
    SUBR = 3'd4,
    CHK  = 3'd5,
    DONE = 3'd6
  } state_t;

endpackage

// File: rtl/fsm_c_ters_ripple_addsub.sv
// Ripple-carry arithmetic built from single-bit full-adder / full-subtractor cells.
//   tam_toplayici : full adder      (a, b, cin)  -> (s, cout)
//   tam_cikarici  : full subtractor (a, b, bin)  -> (d, bout)
//   ripple_addsub : N-bit chain, SUB=0 adds a+b, SUB=1 computes a-b;
//                   carry/borrow into bit 0 is 0, c_out is the final carry/borrow.
module tam_toplayici (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module tam_cikarici (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (bin & ~(a ^ b));
endmodule

module ripple_addsub #(
  parameter int N   = 7,
  parameter bit SUB = 1'b0
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] r,
  output logic         c_out
);
  logic [N:0] c;

  assign c[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_bit
      if (SUB) begin : g_sub
        tam_cikarici u_cell (
          .a    (a[i]),
          .b    (b[i]),
          .bin  (c[i]),
          .d    (r[i]),
          .bout (c[i+1])
        );
      end else begin : g_add
        tam_toplayici u_cell (
          .a    (a[i]),
          .b    (b[i]),
          .cin  (c[i]),
          .s    (r[i]),
          .cout (c[i+1])
        );
      end
    end
  endgenerate

  assign c_out = c[N];
endmodule

// File: rtl/fsm_c_ters.sv
// Recovers operands a,b from s=a+b and d=|a-b|: max=(s+d)/2, min=(s-d)/2.
// One shared ripple adder and one ripple subtractor, sequenced by a small FSM.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset
//   start   : request, sampled in IDLE only
//   s_in    : sum (W+1 bits)          d_in    : difference (W bits)
//   busy    : request in progress     done    : one-cycle result strobe
//   err     : inputs not decodable (held until next done)
//   max_out : larger operand          min_out : smaller operand
//
// state | meaning
// IDLE  | wait for start, capture s/d
// ADD   | load adder operands
// ADDR  | capture s+d
// SUB   | load subtractor operands
// SUBR  | capture s-d and borrow
// CHK   | validate, publish outputs, pulse done
// DONE  | drop done and busy
module fsm_c_ters
  import fsm_c_ters_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W:0]   s_in,
  input  logic [W-1:0] d_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] max_out,
  output logic [W-1:0] min_out
);

  localparam logic [W:0] MAX_OP = {1'b0, {W{1'b1}}};

  state_t state, state_nxt;

  logic [W:0]   sx;
  logic [W-1:0] dx;
  logic [W+1:0] ta, tb, t1;
  logic [W:0]   ca, cb, t2;
  logic         bo;

  logic [W+1:0] add_r;
  logic         add_co;
  logic [W:0]   sub_r;
  logic         sub_bo;
  logic         err_n;
  logic         unused_bits;

  ripple_addsub #(.N(W+2), .SUB(1'b0)) u_add (
    .a     (ta),
    .b     (tb),
    .r     (add_r),
    .c_out (add_co)
  );

  ripple_addsub #(.N(W+1), .SUB(1'b1)) u_sub (
    .a     (ca),
    .b     (cb),
    .r     (sub_r),
    .c_out (sub_bo)
  );

  // Adder is wide enough never to overflow; t2[0] always equals t1[0].
  assign unused_bits = add_co ^ t2[0];

  // Odd sum means s and d differ in parity, so neither halving is exact.
  assign err_n = bo | t1[0] | (t1[W+1:1] > MAX_OP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     state_nxt = ADDR;
      ADDR:    state_nxt = SUB;
      SUB:     state_nxt = SUBR;
      SUBR:    state_nxt = CHK;
      CHK:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sx      <= '0;
      dx      <= '0;
      ta      <= '0;
      tb      <= '0;
      t1      <= '0;
      ca      <= '0;
      cb      <= '0;
      t2      <= '0;
      bo      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      max_out <= '0;
      min_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sx   <= s_in;
            dx   <= d_in;
            busy <= 1'b1;
          end
        end
        ADD: begin
          ta <= {1'b0, sx};
          tb <= {2'b00, dx};
        end
        ADDR: t1 <= add_r;
        SUB: begin
          ca <= sx;
          cb <= {1'b0, dx};
        end
        SUBR: begin
          t2 <= sub_r;
          bo <= sub_bo;
        end
        CHK: begin
          err  <= err_n;
          done <= 1'b1;
          if (!err_n) begin
            max_out <= t1[W:1];
            min_out <= t2[W:1];
          end else begin
            max_out <= '0;
            min_out <= '0;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fsm_c_ters.md
Name: fsm_c_ters

Overview:
- Inverse of the |a-b| formula engine: recovers both operands from their sum and difference.
- Inputs are s = a+b and d = |a-b|. Outputs are max = (s+d)/2 and min = (s-d)/2.
- Multi-cycle FSM that shares one ripple adder and one ripple subtractor, both built from the existing tam_toplayici / tam_cikarici cells.
- Sits downstream of the |a-b| block: consistency checker and decoder for pairs produced by the formula datapath.

Parameters:
- W, 5, operand width; s is W+1 bits, d is W bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset (rst=0 forces reset immediately, independent of clk)
- start  in  1  request; sampled only in IDLE
- s_in  in  W+1  sum a+b
- d_in  in  W  difference |a-b|
- busy  out  1  high from start acceptance until return to IDLE
- done  out  1  one-cycle pulse, result valid
- err  out  1  inputs not decodable; valid with done, held until next done
- max_out  out  W  recovered larger operand
- min_out  out  W  recovered smaller operand

Behaviour:
- Reset (asynchronous, rst=0):
  - state=IDLE.
  - busy, done, err, max_out, min_out all 0.
  - Internal operand/adder/subtractor registers cleared.
  - Reset asserted mid-operation aborts it. No done is produced for the aborted request.
- States, one cycle each, edge k is the edge that samples start=1 in IDLE:
  - IDLE: on start=1, capture sx<=s_in and dx<=d_in, set busy<=1, go to ADD. With start=0, stay in IDLE.
  - ADD (edge k+1): ta<=zero-extended sx, tb<=zero-extended dx, on the W+2-bit adder; go to ADDR.
  - ADDR (k+2): t1<=adder sum (W+2 bits); go to SUB.
  - SUB (k+3): ca<=sx, cb<=zero-extended dx, on the W+1-bit subtractor; go to SUBR.
  - SUBR (k+4): t2<=subtractor difference, bo<=final borrow-out; go to CHK.
  - CHK (k+5):
    - err_n = bo | t1[0] | (t1[W+1:1] > 2^W-1).
    - If err_n=0: max_out<=t1[W+1:1], min_out<=t2[W:1]. Otherwise max_out<=0 and min_out<=0.
    - err<=err_n, done<=1; go to DONE.
  - DONE (k+6): done<=0, busy<=0; go to IDLE.
- Timing:
  - done is high exactly between edges k+5 and k+6.
  - Minimum request spacing is 7 cycles. start held high gives back-to-back operations.
- start while busy is ignored; it is not queued.
- s_in and d_in may change after edge k without affecting the result.
- Outputs and err hold their values until the next CHK or reset.
- Arithmetic:
  - Ripple carry chains, carry-in 0, borrow-in 0. No `+` or `-` operators in the datapath.
  - Parity: s+d odd ⇔ s-d odd, so the t1[0] check covers both halvings.
  - max_out = 2^W-1 is legal (s=2^(W+1)-2, d=0).

Decomposition:
- Shared package: state encodings (IDLE, ADD, ADDR, SUB, SUBR, CHK, DONE; 3-bit) and the default W.
- One natural sub-module: ripple_addsub, a parameterised N-bit chain of tam_toplayici or tam_cikarici selected by a parameter. It is instantiated twice: N=W+2 as adder, N=W+1 as subtractor.
- FSM and check logic stay in fsm_c_ters.

Test Plan:
- Basic decode: s=20, d=4, start pulse at edge k → done at k+5, max=12, min=8, err=0; busy low after k+6.
- Equal operands: s=10, d=0 → max=5, min=5, err=0.
- Upper boundary: s=62, d=0 → max=31, min=31, err=0. s=63, d=31 → sum 94, half 47>31 → err=1, max=min=0.
- Invalid inputs:
  - s=9, d=4 (odd) → err=1, outputs 0.
  - s=3, d=5 (d>s, borrow) → err=1, outputs 0.
  - Next valid request s=7, d=1 clears err → max=4, min=3.
- Protocol: start held high for 20 cycles with s=20, d=4 → done pulses at k+5, k+12, k+19. Extra start pulses during busy produce no extra done.
- Async reset mid-op: rst=0 between edges k+3 and k+4 → busy, done, err, max_out, min_out all 0 immediately, before the next edge. After release, no done until a new start.
